secret_code_gen: RTL

//  Produces the 4-slot secret code that the feedback stage scores guesses against.
//  A free-running 16-bit Galois LFSR is sampled one slot per cycle. Out-of-range

---
 rtl/mastermind_pkg.sv | 40 ++++
 rtl/lfsr16.sv | 36 +++
 rtl/secret_code_gen.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mastermind_pkg.sv
// Shared widths, colour/state enums and the LFSR step function for the code generator.
// Pure declarations; no clocked logic.
package mastermind_pkg;

    localparam int COLOR_W   = 3;
    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W    = $clog2(NUM_SLOTS);
    localparam int LFSR_W    = 16;

    typedef enum logic [COLOR_W-1:0] {
        RED    = 3'd0,
        GREEN  = 3'd1,
        BLUE   = 3'd2,
        YELLOW = 3'd3,
        ORANGE = 3'd4,
        PURPLE = 3'd5,
        BLACK  = 3'd6,
        WHITE  = 3'd7
    } color_e;

    typedef enum logic {
        DRAW  = 1'b0,
        VALID = 1'b1
    } state_e;

    // Galois right-shift step; stir lands in bit 0 and the all-zero lock-up state
    // is replaced by the seed.
    function automatic logic [LFSR_W-1:0] lfsr_next(
        input logic [LFSR_W-1:0] cur,
        input logic              stir,
        input logic [LFSR_W-1:0] taps,
        input logic [LFSR_W-1:0] seed
    );
        logic [LFSR_W-1:0] nxt;
        nxt    = (cur >> 1) ^ (cur[0] ? taps : '0);
        nxt[0] = nxt[0] ^ stir;
        return (nxt == '0) ? seed : nxt;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR with stir input and zero guard.
// State advances every cycle; reset loads SEED.
module lfsr16
    import mastermind_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1,
    parameter logic [LFSR_W-1:0] TAPS = 16'hB400
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stir,
    output logic [LFSR_W-1:0] state
);

    if (SEED == '0) begin : g_seed_err
        $error("lfsr16: SEED must be nonzero");
    end

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_next(lfsr_q, stir, TAPS, SEED);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state = lfsr_q;

endmodule

// File: rtl/secret_code_gen.sv
// Draws a 4-slot secret code from the LFSR, one candidate per cycle, rejecting
// out-of-range and (optionally) duplicate colours; holds the code until new_game.
module secret_code_gen
    import mastermind_pkg::*;
#(
    parameter int                NUM_COLORS    = 6,
    parameter bit                ALLOW_REPEATS = 1'b0,
    parameter logic [LFSR_W-1:0] SEED          = 16'hACE1,
    parameter logic [LFSR_W-1:0] TAPS          = 16'hB400
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               new_game,
    input  logic               stir,
    output logic [COLOR_W-1:0] code0,
    output logic [COLOR_W-1:0] code1,
    output logic [COLOR_W-1:0] code2,
    output logic [COLOR_W-1:0] code3,
    output logic               code_valid,
    output logic               busy
);

    if (NUM_COLORS > 8 || NUM_COLORS < 1) begin : g_colors_err
        $error("secret_code_gen: NUM_COLORS must be 1..8");
    end
    if (!ALLOW_REPEATS && NUM_COLORS < NUM_SLOTS) begin : g_unique_err
        $error("secret_code_gen: too few colours for a code without repeats");
    end

    logic [LFSR_W-1:0]  lfsr_w;
    logic [COLOR_W-1:0] cand;
    logic               cand_in_range;
    logic               cand_dup;
    logic               accept;

    state_e             state_q;
    state_e             state_d;
    logic [SLOT_W-1:0]  slot_q;
    logic [SLOT_W-1:0]  slot_d;
    logic [COLOR_W-1:0] code_q [NUM_SLOTS];
    logic [COLOR_W-1:0] code_d [NUM_SLOTS];

    lfsr16 #(
        .SEED (SEED),
        .TAPS (TAPS)
    ) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .stir    (stir),
        .state   (lfsr_w)
    );

    // Candidate is taken from the pre-update LFSR value.
    assign cand          = lfsr_w[COLOR_W-1:0];
    assign cand_in_range = (32'(cand) < NUM_COLORS);

    // Only slots below the current slot count; stale codes from an aborted draw
    // never block a candidate.
    always_comb begin
        cand_dup = 1'b0;
        for (int i = 0; i < NUM_SLOTS - 1; i++) begin
            if ((slot_q > SLOT_W'(i)) && (code_q[i] == cand)) begin
                cand_dup = 1'b1;
            end
        end
    end

    assign accept = (state_q == DRAW) && !new_game && cand_in_range
                    && (ALLOW_REPEATS || !cand_dup);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= DRAW;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DRAW: begin
                if (accept && (slot_q == SLOT_W'(NUM_SLOTS - 1))) begin
                    state_d = VALID;
                end
            end
            VALID: begin
                if (new_game) begin
                    state_d = DRAW;
                end
            end
            default: state_d = DRAW;
        endcase
    end

    always_comb begin
        code_valid = (state_q == VALID);
        busy       = (state_q == DRAW);
    end

    // Slot wraps to 0 on the final accept, so VALID is always entered at slot 0.
    always_comb begin
        slot_d = slot_q;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            code_d[i] = code_q[i];
        end
        if (new_game) begin
            slot_d = '0;
        end else if (accept) begin
            code_d[slot_q] = cand;
            slot_d         = slot_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            slot_q <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                code_q[i] <= '0;
            end
        end else begin
            slot_q <= slot_d;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                code_q[i] <= code_d[i];
            end
        end
    end

    assign code0 = code_q[0];
    assign code1 = code_q[1];
    assign code2 = code_q[2];
    assign code3 = code_q[3];

endmodule
